admo_dmem: RTL and testbench

Data-memory responder for the ADMO core: the slave end of the load-store unit's memory interface. Accepts one byte/half/word load or store request at a time over a valid/ready handshake, services it after a fixed number of wait states against an internal word-organised array, and returns read data or a write acknowledge over a second valid/ready handshake. It sits between the LSU and the core's data address space and is the standard on-chip data RAM model for simulation and FPGA builds.

---
 rtl/admo_dmem_pkg.sv | 34 +++
 rtl/admo_dmem_align.sv | 65 ++++++
 rtl/admo_dmem.sv | 169 ++++++++++++++++
 tb/tb_admo_dmem.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/admo_dmem_pkg.sv
// Shared encodings for the ADMO data-memory responder: access lengths, direction, FSM states.
// The ADMO_DMEM_ERR_EN build option is consumed by admo_dmem_align.
package admo_dmem_pkg;

    localparam int unsigned LEN_W   = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LANES   = 4;
    localparam int unsigned WORD_W  = 32;

    localparam logic [LEN_W-1:0] LEN_BYTE = 2'b00;
    localparam logic [LEN_W-1:0] LEN_HALF = 2'b01;
    localparam logic [LEN_W-1:0] LEN_WORD = 2'b10;
    localparam logic [LEN_W-1:0] LEN_RSVD = 2'b11;

    localparam logic RW_LOAD  = 1'b0;
    localparam logic RW_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Unshifted lane mask for a given access length (reserved maps to no lanes).
    function automatic logic [LANES-1:0] base_lanes(input logic [LEN_W-1:0] len);
        case (len)
            LEN_BYTE: base_lanes = 4'b0001;
            LEN_HALF: base_lanes = 4'b0011;
            LEN_WORD: base_lanes = 4'b1111;
            default:  base_lanes = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/admo_dmem_align.sv
// Byte-lane steering for admo_dmem: byte enables, store replication, load alignment.
// ADMO_DMEM_ERR_EN: flag misaligned/reserved accesses instead of masking address bits.
module admo_dmem_align
    import admo_dmem_pkg::*;
(
    input  logic [LEN_W-1:0]  i_len,
    input  logic [1:0]        i_addr_lo,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [WORD_W-1:0] i_rword,
    output logic [LANES-1:0]  o_be,
    output logic [WORD_W-1:0] o_wdata,
    output logic              o_misalign,
    output logic [WORD_W-1:0] o_rdata
);

    logic [LEN_W-1:0]  w_len;
    logic [1:0]        w_off;
    logic [WORD_W-1:0] w_shifted;

    // Effective length and lane offset
    always_comb begin
        w_len      = i_len;
        w_off      = i_addr_lo;
        o_misalign = 1'b0;
`ifdef ADMO_DMEM_ERR_EN
        case (i_len)
            LEN_HALF: o_misalign = i_addr_lo[0];
            LEN_WORD: o_misalign = (i_addr_lo != 2'b00);
            LEN_RSVD: o_misalign = 1'b1;
            default:  o_misalign = 1'b0;
        endcase
`else
        if (i_len == LEN_RSVD) begin
            w_len = LEN_WORD;
        end
        case (w_len)
            LEN_HALF: w_off = {i_addr_lo[1], 1'b0};
            LEN_WORD: w_off = 2'b00;
            default:  w_off = i_addr_lo;
        endcase
`endif
    end

    always_comb begin
        o_be    = LANES'(base_lanes(w_len) << w_off);
        o_wdata = i_wdata;
        case (w_len)
            LEN_BYTE: o_wdata = {4{i_wdata[7:0]}};
            LEN_HALF: o_wdata = {2{i_wdata[15:0]}};
            default:  o_wdata = i_wdata;
        endcase
    end

    assign w_shifted = i_rword >> {w_off, 3'b000};

    always_comb begin
        o_rdata = w_shifted;
        case (w_len)
            LEN_BYTE: o_rdata = {24'd0, w_shifted[7:0]};
            LEN_HALF: o_rdata = {16'd0, w_shifted[15:0]};
            default:  o_rdata = w_shifted;
        endcase
    end

endmodule

// File: rtl/admo_dmem.sv
// ADMO data-memory responder: one LSU request at a time, fixed wait states, word-organised array.
// Build option ADMO_DMEM_ERR_EN enables misalignment/reserved-length error responses.
module admo_dmem
    import admo_dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_rw_i,
    input  logic [LEN_W-1:0]      req_len_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned AW_LO = IDX_W + 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rw;
    logic [LEN_W-1:0]      r_len;
    logic [AW_LO-1:0]      r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [WORD_W-1:0]     r_mem [DEPTH];

    logic                  w_live;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_sel_rw;
    logic [LEN_W-1:0]      w_sel_len;
    logic [AW_LO-1:0]      w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [IDX_W-1:0]      w_idx;
    logic [WORD_W-1:0]     w_rword;
    logic [LANES-1:0]      w_be;
    logic [WORD_W-1:0]     w_wdata_rep;
    logic                  w_misalign;
    logic [WORD_W-1:0]     w_load_data;
    logic                  w_err;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_rsp_data;
    logic                  w_unused;

    assign w_live   = (r_state == ST_IDLE);
    assign w_accept = w_live & r_req_ready & req_valid_i;

    // With zero wait states the array is accessed on the accept edge, straight from the inputs
    assign w_enter_resp = (WAIT_CYCLES == 0) ? w_accept
                                             : ((r_state == ST_WAIT) && (r_cnt == '0));

    assign w_sel_rw   = w_live ? req_rw_i                : r_rw;
    assign w_sel_len  = w_live ? req_len_i               : r_len;
    assign w_sel_addr = w_live ? req_addr_i[AW_LO-1:0]   : r_addr;
    assign w_sel_data = w_live ? req_data_i              : r_wdata;

    assign w_idx   = w_sel_addr[AW_LO-1:2];
    assign w_rword = r_mem[w_idx];

    admo_dmem_align u_align (
        .i_len      (w_sel_len),
        .i_addr_lo  (w_sel_addr[1:0]),
        .i_wdata    (w_sel_data),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wdata_rep),
        .o_misalign (w_misalign),
        .o_rdata    (w_load_data)
    );

    assign w_err      = w_misalign;
    assign w_mem_we   = w_enter_resp & (w_sel_rw == RW_STORE) & ~w_err;
    assign w_rsp_data = ((w_sel_rw == RW_STORE) || w_err) ? '0 : w_load_data;

    // Address bits above the array size alias
    assign w_unused = ^req_addr_i[ADDR_WIDTH-1:AW_LO];

    // Array contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
            r_rw        <= RW_LOAD;
            r_len       <= LEN_BYTE;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_rw        <= req_rw_i;
                        r_len       <= req_len_i;
                        r_addr      <= req_addr_i[AW_LO-1:0];
                        r_wdata     <= req_data_i;
                        r_req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_rsp_data;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rsp_data;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_admo_dmem.sv
// Scoreboard bench for admo_dmem: directed requests push expected responses, a monitor checks them.
module tb_admo_dmem;

    localparam int unsigned DEPTH       = 512;
    localparam int unsigned WAIT_CYCLES = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [1:0]  req_len = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_rdy = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_valid = 1'b0;

    admo_dmem #(
        .DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_rw_i(req_rw), .req_len_i(req_len), .req_addr_i(req_addr), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_rdy),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: latency on rising valid, payload on each handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rsp_valid && !prev_valid) begin
                check("latency", 32'(cyc - acc_cyc), 32'(WAIT_CYCLES));
            end
            prev_valid = rsp_valid;
            if (rsp_valid && rsp_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got data 0x%08h with empty scoreboard", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic send(input logic rw, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_d, input logic exp_e);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = rw;
        req_len   = len;
        req_addr  = addr;
        req_data  = data;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_timeout: req_ready stayed 0 for addr 0x%08h", addr);
            req_valid = 1'b0;
        end else begin
            e.data = exp_d;
            e.err  = exp_e;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            acc_cyc   = cyc;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset behaviour
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Word, byte and half traffic on word 0x10
        send(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        send(1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        send(1'b1, 2'b00, 32'h11, 32'h000000AA, 32'h0, 1'b0);
        send(1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
        send(1'b0, 2'b01, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
        send(1'b0, 2'b00, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        send(1'b1, 2'b10, 32'h20, 32'h11111111, 32'h0, 1'b0);
        send(1'b1, 2'b01, 32'h22, 32'h0000BEEF, 32'h0, 1'b0);
        drain();

        // Response back-pressure with a competing request
        rsp_rdy = 1'b0;
        send(1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", rsp_data, 32'hDEADAAEF);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            if (i == 0) begin
                req_valid = 1'b1;
                req_rw    = 1'b1;
                req_len   = 2'b10;
                req_addr  = 32'h20;
                req_data  = 32'h55555555;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_rdy   = 1'b1;
        send(1'b0, 2'b10, 32'h20, 32'h0, 32'hBEEF1111, 1'b0);

        // Misaligned and reserved-length accesses
`ifdef ADMO_DMEM_ERR_EN
        send(1'b1, 2'b01, 32'h11, 32'h00001234, 32'h0, 1'b1);
        send(1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
        send(1'b0, 2'b10, 32'h13, 32'h0, 32'h0, 1'b1);
        send(1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1);
`else
        send(1'b1, 2'b01, 32'h11, 32'h00001234, 32'h0, 1'b0);
        send(1'b0, 2'b10, 32'h10, 32'h0, 32'hDEAD1234, 1'b0);
        send(1'b0, 2'b10, 32'h13, 32'h0, 32'hDEAD1234, 1'b0);
        send(1'b0, 2'b11, 32'h12, 32'h0, 32'hDEAD1234, 1'b0);
`endif

        // Address aliasing above the array size
        send(1'b1, 2'b10, DEPTH * 4 + 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
        send(1'b0, 2'b10, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
        send(1'b0, 2'b10, 32'hFFFFF810, 32'h0, 32'hCAFEF00D, 1'b0);
        drain();

        // Reset while a store sits in WAIT: it must never land
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_len   = 2'b10;
        req_addr  = 32'h10;
        req_data  = 32'h12345678;
        check("rstw_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rstw_valid", 32'(rsp_valid), 32'd0);
        check("rstw_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstw_post_ready", 32'(req_ready), 32'd1);
        send(1'b0, 2'b10, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
